calc2_dispatch_arbiter: RTL and testbench
=========================================

// Module: calc2_dispatch_arbiter
// PURPOSE
//  Sits between the four request ports and the shared adder and shifter datapaths.
//  Per cycle it grants at most one request to each unit, round-robin per unit.
//  Tracks outstanding {port,tag} pairs and per-unit credits; rejects illegal commands.
//  Issue outputs are registered and feed the alu input stages. Unit done strobes retire tags.
// PARAMETERS
//  DATA_W        32  operand width
//  ADD_CREDITS    4  max adder ops in flight (1..15)
//  SHIFT_CREDITS  4  max shifter ops in flight (1..15)
// PORTS
//  c_clk                in   1       functional clock, rising edge
//  reset                in   1       asynchronous, active-low
//  reqN_cmd_in  (N=1..4) in  4       0=idle, 1=add, 2=sub, 5=shl, 6=shr, others illegal
//  reqN_tag_in          in   2       requester tag
//  reqN_data1_in        in   DATA_W  operand 1
//  reqN_data2_in        in   DATA_W  operand 2
//  reqN_ack             out  1       one-cycle accept pulse
//  portN_invalid_op     out  1       one-cycle illegal-command pulse
//  portN_invalid_tag    out  2       tag of the rejected request
//  adder_vld            out  1       adder issue valid, one cycle
//  adder_cmd            out  4       issued command
//  adder_tag            out  4       {port[1:0] (0..3 = ports 1..4), tag[1:0]}
//  adder_data1/2        out  DATA_W  issued operands
//  shift_vld/cmd/tag/data1/data2  out  as adder_*, for the shifter
//  adder_done, shift_done          in  1  unit completed one op
//  adder_done_tag, shift_done_tag  in  4  {port,tag} of the completed op
//  proto_err            out  1       sticky protocol error
// BEHAVIOUR
//  Reset (async, low): all outputs 0; busy[15:0]=0; credit counters=0; RR pointers=port1; proto_err=0.
//  Request valid: cmd!=0. The requester holds cmd/tag/data until it sees ack.
//  Eligible in cycle C: valid, busy[{port,tag}]=0, ack not high in C, and unit count < credits.
//  Per unit: among eligible ports whose cmd maps to the unit, pick the first at or after the RR pointer.
//  On grant in C, the following are registered at edge C+1:
//   - unit_vld=1, cmd/tag/data copied, reqN_ack=1, busy set, count+1, pointer=winner+1 (mod 4).
//  Latency: request stable in C -> issue and ack in C+1. Both units can issue in the same cycle.
//  Illegal cmd, port not acked in C: in C+1, ack=1, portN_invalid_op=1, invalid_tag=tag.
//   No busy/credit effect. Illegal commands ignore the busy check.
//  Done with busy bit set: busy clears at the next edge; count-1.
//   The same {port,tag} is eligible the cycle after the clear.
//  Grant and done on the same unit, same cycle: count unchanged.
//  Grant and done on the same {port,tag}, same cycle: not possible, because busy blocks the grant.
//  Done with busy=0, or with count=0: ignored; proto_err=1 (sticky until reset).
//  Count never exceeds credits. At count==credits, requests wait with no ack, and the pointer holds.
//  Non-winners keep waiting; RR guarantees service within 4 grants.
//  Reset mid-operation drops all in-flight state. Done strobes after reset set proto_err.
// TESTING
//  1. Reset, then req1 add tag1 a=3 b=4 -> next cycle adder_vld=1, cmd=1, tag=4'b0001, data1=3, data2=4, req1_ack=1.
//  2. All 4 ports add simultaneously, done returned at once ->
//     grants in order 1,2,3,4 on consecutive cycles; the next round starts at port1.
//  3. ADD_CREDITS=2, 3 adds, no done -> 2 issued, third held.
//     adder_done tag=first -> third issues 2 cycles later.
//  4. req2 shl + req3 sub in the same cycle -> shift_vld and adder_vld both high next cycle, both acks.
//  5. req4 cmd=4'hF tag=3 -> port4_invalid_op=1, invalid_tag=3, ack=1; no unit vld; credits unchanged.
//  6. adder_done with no outstanding op -> proto_err=1 and remains 1.
//     Async reset low mid-issue -> all outputs 0 immediately.

Source files
------------

// File: rtl/calc2_dispatch_arbiter.sv
// calc2_dispatch_arbiter
//   Dispatches requests from four ports to the shared adder and shifter
//   datapaths. Each unit has its own round-robin pointer and grants at most
//   one request per cycle. Outstanding {port,tag} pairs are tracked in a
//   16-bit busy map. A per-unit credit counter limits the number of ops in
//   flight. Illegal commands are acknowledged and reported. Done strobes
//   that do not match an outstanding op set a sticky protocol error.
//
// Ports
//   c_clk, reset                 clock (rising edge), async active-low reset
//   reqN_cmd_in/tag_in           request command (0 idle, 1 add, 2 sub,
//                                5 shl, 6 shr) and requester tag
//   reqN_data1_in/data2_in       operands
//   reqN_ack                     one-cycle accept pulse (grant or reject)
//   portN_invalid_op/_tag        one-cycle illegal-command pulse and its tag
//   adder_*/shift_*              registered issue to each unit;
//                                tag = {port[1:0], tag[1:0]}
//   adder_done/shift_done(_tag)  unit retired the op with this {port,tag}
//   proto_err                    sticky: unmatched done strobe seen
module calc2_dispatch_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADD_CREDITS   = 4,
    parameter int SHIFT_CREDITS = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [1:0]        req1_tag_in,
    input  logic [DATA_W-1:0] req1_data1_in,
    input  logic [DATA_W-1:0] req1_data2_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [1:0]        req2_tag_in,
    input  logic [DATA_W-1:0] req2_data1_in,
    input  logic [DATA_W-1:0] req2_data2_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [1:0]        req3_tag_in,
    input  logic [DATA_W-1:0] req3_data1_in,
    input  logic [DATA_W-1:0] req3_data2_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [1:0]        req4_tag_in,
    input  logic [DATA_W-1:0] req4_data1_in,
    input  logic [DATA_W-1:0] req4_data2_in,
    output logic              req1_ack,
    output logic              req2_ack,
    output logic              req3_ack,
    output logic              req4_ack,
    output logic              port1_invalid_op,
    output logic              port2_invalid_op,
    output logic              port3_invalid_op,
    output logic              port4_invalid_op,
    output logic [1:0]        port1_invalid_tag,
    output logic [1:0]        port2_invalid_tag,
    output logic [1:0]        port3_invalid_tag,
    output logic [1:0]        port4_invalid_tag,
    output logic              adder_vld,
    output logic [3:0]        adder_cmd,
    output logic [3:0]        adder_tag,
    output logic [DATA_W-1:0] adder_data1,
    output logic [DATA_W-1:0] adder_data2,
    output logic              shift_vld,
    output logic [3:0]        shift_cmd,
    output logic [3:0]        shift_tag,
    output logic [DATA_W-1:0] shift_data1,
    output logic [DATA_W-1:0] shift_data2,
    input  logic              adder_done,
    input  logic [3:0]        adder_done_tag,
    input  logic              shift_done,
    input  logic [3:0]        shift_done_tag,
    output logic              proto_err
);

    localparam logic [3:0] ADD_CRED = 4'(ADD_CREDITS);
    localparam logic [3:0] SHF_CRED = 4'(SHIFT_CREDITS);

    // Per-port views of the request inputs
    logic [3:0]        cmd  [4];
    logic [1:0]        tag  [4];
    logic [DATA_W-1:0] dat1 [4];
    logic [DATA_W-1:0] dat2 [4];

    assign cmd[0] = req1_cmd_in;  assign tag[0] = req1_tag_in;
    assign cmd[1] = req2_cmd_in;  assign tag[1] = req2_tag_in;
    assign cmd[2] = req3_cmd_in;  assign tag[2] = req3_tag_in;
    assign cmd[3] = req4_cmd_in;  assign tag[3] = req4_tag_in;
    assign dat1[0] = req1_data1_in; assign dat2[0] = req1_data2_in;
    assign dat1[1] = req2_data1_in; assign dat2[1] = req2_data2_in;
    assign dat1[2] = req3_data1_in; assign dat2[2] = req3_data2_in;
    assign dat1[3] = req4_data1_in; assign dat2[3] = req4_data2_in;

    // State
    logic [3:0]        ack_q,     ack_d;
    logic [3:0]        inv_q,     inv_d;
    logic [7:0]        invtag_q,  invtag_d;
    logic [15:0]       busy_q,    busy_d;
    logic [3:0]        add_cnt_q, add_cnt_d;
    logic [3:0]        shf_cnt_q, shf_cnt_d;
    logic [1:0]        add_ptr_q, add_ptr_d;
    logic [1:0]        shf_ptr_q, shf_ptr_d;
    logic              a_vld_q,   a_vld_d;
    logic [3:0]        a_cmd_q,   a_cmd_d;
    logic [3:0]        a_tag_q,   a_tag_d;
    logic [DATA_W-1:0] a_d1_q,    a_d1_d;
    logic [DATA_W-1:0] a_d2_q,    a_d2_d;
    logic              s_vld_q,   s_vld_d;
    logic [3:0]        s_cmd_q,   s_cmd_d;
    logic [3:0]        s_tag_q,   s_tag_d;
    logic [DATA_W-1:0] s_d1_q,    s_d1_d;
    logic [DATA_W-1:0] s_d2_q,    s_d2_d;
    logic              perr_q,    perr_d;

    // Combinational decisions
    logic [3:0] add_elig, shf_elig, illegal;
    logic       add_gnt,  shf_gnt;
    logic [1:0] add_win,  shf_win;
    logic [1:0] idx;
    logic       add_done_ok, shf_done_ok;

    always_comb begin
        add_elig = '0;
        shf_elig = '0;
        illegal  = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            // A port already acked this cycle is still presenting the old request
            if (cmd[p] != 4'd0 && !ack_q[p]) begin
                case (cmd[p])
                    4'd1, 4'd2: add_elig[p] = !busy_q[{2'(p), tag[p]}] && (add_cnt_q < ADD_CRED);
                    4'd5, 4'd6: shf_elig[p] = !busy_q[{2'(p), tag[p]}] && (shf_cnt_q < SHF_CRED);
                    default:    illegal[p]  = 1'b1;
                endcase
            end
        end

        // Round-robin: first eligible port at or after the pointer
        add_gnt = 1'b0;
        add_win = '0;
        shf_gnt = 1'b0;
        shf_win = '0;
        idx     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = add_ptr_q + 2'(i);
            if (!add_gnt && add_elig[idx]) begin
                add_gnt = 1'b1;
                add_win = idx;
            end
            idx = shf_ptr_q + 2'(i);
            if (!shf_gnt && shf_elig[idx]) begin
                shf_gnt = 1'b1;
                shf_win = idx;
            end
        end

        add_done_ok = adder_done && busy_q[adder_done_tag] && (add_cnt_q != 4'd0);
        shf_done_ok = shift_done && busy_q[shift_done_tag] && (shf_cnt_q != 4'd0);
    end

    always_comb begin
        ack_d    = illegal;
        inv_d    = illegal;
        invtag_d = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            if (illegal[p]) invtag_d[2*p +: 2] = tag[p];
        end

        a_vld_d = add_gnt;
        a_cmd_d = '0;
        a_tag_d = '0;
        a_d1_d  = '0;
        a_d2_d  = '0;
        s_vld_d = shf_gnt;
        s_cmd_d = '0;
        s_tag_d = '0;
        s_d1_d  = '0;
        s_d2_d  = '0;
        busy_d    = busy_q;
        add_ptr_d = add_ptr_q;
        shf_ptr_d = shf_ptr_q;

        // Clears first: a done can never target the {port,tag} granted this
        // cycle because the busy bit blocked that grant.
        if (add_done_ok) busy_d[adder_done_tag] = 1'b0;
        if (shf_done_ok) busy_d[shift_done_tag] = 1'b0;

        if (add_gnt) begin
            ack_d[add_win] = 1'b1;
            a_cmd_d   = cmd[add_win];
            a_tag_d   = {add_win, tag[add_win]};
            a_d1_d    = dat1[add_win];
            a_d2_d    = dat2[add_win];
            busy_d[{add_win, tag[add_win]}] = 1'b1;
            add_ptr_d = add_win + 2'd1;
        end
        if (shf_gnt) begin
            ack_d[shf_win] = 1'b1;
            s_cmd_d   = cmd[shf_win];
            s_tag_d   = {shf_win, tag[shf_win]};
            s_d1_d    = dat1[shf_win];
            s_d2_d    = dat2[shf_win];
            busy_d[{shf_win, tag[shf_win]}] = 1'b1;
            shf_ptr_d = shf_win + 2'd1;
        end

        add_cnt_d = add_cnt_q + {3'b000, add_gnt} - {3'b000, add_done_ok};
        shf_cnt_d = shf_cnt_q + {3'b000, shf_gnt} - {3'b000, shf_done_ok};

        perr_d = perr_q | (adder_done & ~add_done_ok) | (shift_done & ~shf_done_ok);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            ack_q     <= '0;
            inv_q     <= '0;
            invtag_q  <= '0;
            busy_q    <= '0;
            add_cnt_q <= '0;
            shf_cnt_q <= '0;
            add_ptr_q <= '0;
            shf_ptr_q <= '0;
            a_vld_q   <= 1'b0;
            a_cmd_q   <= '0;
            a_tag_q   <= '0;
            a_d1_q    <= '0;
            a_d2_q    <= '0;
            s_vld_q   <= 1'b0;
            s_cmd_q   <= '0;
            s_tag_q   <= '0;
            s_d1_q    <= '0;
            s_d2_q    <= '0;
            perr_q    <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            inv_q     <= inv_d;
            invtag_q  <= invtag_d;
            busy_q    <= busy_d;
            add_cnt_q <= add_cnt_d;
            shf_cnt_q <= shf_cnt_d;
            add_ptr_q <= add_ptr_d;
            shf_ptr_q <= shf_ptr_d;
            a_vld_q   <= a_vld_d;
            a_cmd_q   <= a_cmd_d;
            a_tag_q   <= a_tag_d;
            a_d1_q    <= a_d1_d;
            a_d2_q    <= a_d2_d;
            s_vld_q   <= s_vld_d;
            s_cmd_q   <= s_cmd_d;
            s_tag_q   <= s_tag_d;
            s_d1_q    <= s_d1_d;
            s_d2_q    <= s_d2_d;
            perr_q    <= perr_d;
        end
    end

    assign req1_ack          = ack_q[0];
    assign req2_ack          = ack_q[1];
    assign req3_ack          = ack_q[2];
    assign req4_ack          = ack_q[3];
    assign port1_invalid_op  = inv_q[0];
    assign port2_invalid_op  = inv_q[1];
    assign port3_invalid_op  = inv_q[2];
    assign port4_invalid_op  = inv_q[3];
    assign port1_invalid_tag = invtag_q[1:0];
    assign port2_invalid_tag = invtag_q[3:2];
    assign port3_invalid_tag = invtag_q[5:4];
    assign port4_invalid_tag = invtag_q[7:6];
    assign adder_vld         = a_vld_q;
    assign adder_cmd         = a_cmd_q;
    assign adder_tag         = a_tag_q;
    assign adder_data1       = a_d1_q;
    assign adder_data2       = a_d2_q;
    assign shift_vld         = s_vld_q;
    assign shift_cmd         = s_cmd_q;
    assign shift_tag         = s_tag_q;
    assign shift_data1       = s_d1_q;
    assign shift_data2       = s_d2_q;
    assign proto_err         = perr_q;

endmodule

// File: tb/tb_calc2_dispatch_arbiter.sv
// Directed table-driven bench for calc2_dispatch_arbiter (adder credits = 2).
// Each table row gives the inputs for one cycle and the outputs expected
// right after the following rising edge.
module tb_calc2_dispatch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_v = '0;
    logic [7:0]  tag_v = '0;
    logic        adn = 1'b0, sdn = 1'b0;
    logic [3:0]  adt = '0, sdt = '0;

    logic [31:0] D1 [4] = '{32'h3, 32'h21, 32'h31, 32'h41};
    logic [31:0] D2 [4] = '{32'h4, 32'h22, 32'h32, 32'h42};

    logic [3:0]  ack, inv;
    logic [7:0]  itag;
    logic        avld, svld, perr;
    logic [3:0]  acmd, atag, scmd, stag;
    logic [31:0] ad1, ad2, sd1, sd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    calc2_dispatch_arbiter #(.DATA_W(32), .ADD_CREDITS(2), .SHIFT_CREDITS(4)) dut (
        .c_clk(clk), .reset(rst_n),
        .req1_cmd_in(cmd_v[3:0]),   .req1_tag_in(tag_v[1:0]), .req1_data1_in(D1[0]), .req1_data2_in(D2[0]),
        .req2_cmd_in(cmd_v[7:4]),   .req2_tag_in(tag_v[3:2]), .req2_data1_in(D1[1]), .req2_data2_in(D2[1]),
        .req3_cmd_in(cmd_v[11:8]),  .req3_tag_in(tag_v[5:4]), .req3_data1_in(D1[2]), .req3_data2_in(D2[2]),
        .req4_cmd_in(cmd_v[15:12]), .req4_tag_in(tag_v[7:6]), .req4_data1_in(D1[3]), .req4_data2_in(D2[3]),
        .req1_ack(ack[0]), .req2_ack(ack[1]), .req3_ack(ack[2]), .req4_ack(ack[3]),
        .port1_invalid_op(inv[0]), .port2_invalid_op(inv[1]),
        .port3_invalid_op(inv[2]), .port4_invalid_op(inv[3]),
        .port1_invalid_tag(itag[1:0]), .port2_invalid_tag(itag[3:2]),
        .port3_invalid_tag(itag[5:4]), .port4_invalid_tag(itag[7:6]),
        .adder_vld(avld), .adder_cmd(acmd), .adder_tag(atag), .adder_data1(ad1), .adder_data2(ad2),
        .shift_vld(svld), .shift_cmd(scmd), .shift_tag(stag), .shift_data1(sd1), .shift_data2(sd2),
        .adder_done(adn), .adder_done_tag(adt), .shift_done(sdn), .shift_done_tag(sdt),
        .proto_err(perr)
    );

    typedef struct {
        logic [15:0] cmd;  logic [7:0] tag;
        logic        adn;  logic [3:0] adt;  logic sdn; logic [3:0] sdt;
        logic [3:0]  ack;  logic [3:0] inv;  logic [7:0] itag;
        logic        av;   logic [3:0] ac;   logic [3:0] at;
        logic        sv;   logic [3:0] sc;   logic [3:0] st;
        logic        perr;
    } vec_t;

    localparam int NV = 23;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{ack, inv, itag, avld, acmd, atag, ad1, ad2, svld, scmd, stag, sd1, sd2, perr};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cmd       tag    adn   adt   sdn   sdt  | ack  inv  itag   av    ac    at    sv    sc    st   perr
        // all four add at once, dones returned as issued: order 1,2,3,4 then port1
        v[0]  = '{16'h1111, 8'hE4, 1'b0, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[1]  = '{16'h1111, 8'hE4, 1'b1, 4'h0, 1'b0, 4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h1, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0};
        v[2]  = '{16'h1110, 8'hE4, 1'b1, 4'h5, 1'b0, 4'h0, 4'h4, 4'h0, 8'h00, 1'b1, 4'h1, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0};
        v[3]  = '{16'h1100, 8'hE4, 1'b1, 4'hA, 1'b0, 4'h0, 4'h8, 4'h0, 8'h00, 1'b1, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
        v[4]  = '{16'h1001, 8'hE4, 1'b1, 4'hF, 1'b0, 4'h0, 4'h1, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[5]  = '{16'h0001, 8'hE4, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        // credits=2: three adds, two issue, third waits until a done
        v[6]  = '{16'h0111, 8'h39, 1'b0, 4'h0, 1'b0, 4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h1, 4'h6, 1'b0, 4'h0, 4'h0, 1'b0};
        v[7]  = '{16'h0111, 8'h39, 1'b0, 4'h0, 1'b0, 4'h0, 4'h4, 4'h0, 8'h00, 1'b1, 4'h1, 4'hB, 1'b0, 4'h0, 4'h0, 1'b0};
        v[8]  = '{16'h0101, 8'h39, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[9]  = '{16'h0001, 8'h39, 1'b1, 4'h6, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[10] = '{16'h0001, 8'h39, 1'b0, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 8'h00, 1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0};
        v[11] = '{16'h0001, 8'h39, 1'b1, 4'hB, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[12] = '{16'h0000, 8'h39, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        // shl on port2 and sub on port3 issue together
        v[13] = '{16'h0250, 8'h20, 1'b0, 4'h0, 1'b0, 4'h0, 4'h6, 4'h0, 8'h00, 1'b1, 4'h2, 4'hA, 1'b1, 4'h5, 4'h4, 1'b0};
        v[14] = '{16'h0250, 8'h20, 1'b1, 4'hA, 1'b1, 4'h4, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        // illegal cmd on port4 tag3 alongside shr on port1; held during ack -> no repeat
        v[15] = '{16'hF006, 8'hC1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h9, 4'h8, 8'hC0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h6, 4'h1, 1'b0};
        v[16] = '{16'hF006, 8'hC1, 1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        // both adder credits still free after the illegal command
        v[17] = '{16'h0011, 8'h0F, 1'b0, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 8'h00, 1'b1, 4'h1, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0};
        v[18] = '{16'h0011, 8'h0F, 1'b0, 4'h0, 1'b0, 4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h1, 4'h7, 1'b0, 4'h0, 4'h0, 1'b0};
        // illegal cmd on a busy {port,tag} is still rejected
        v[19] = '{16'h0014, 8'h0F, 1'b1, 4'h3, 1'b0, 4'h0, 4'h1, 4'h1, 8'h03, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        v[20] = '{16'h0004, 8'h0F, 1'b1, 4'h7, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        // stray done -> sticky proto_err
        v[21] = '{16'h0000, 8'h0F, 1'b1, 4'h7, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1};
        v[22] = '{16'h0000, 8'h0F, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cmd_v = v[i].cmd;
            tag_v = v[i].tag;
            adn = v[i].adn; adt = v[i].adt;
            sdn = v[i].sdn; sdt = v[i].sdt;
            step();
            chk($sformatf("row%0d_ack", i),  {28'd0, ack},  {28'd0, v[i].ack});
            chk($sformatf("row%0d_inv", i),  {28'd0, inv},  {28'd0, v[i].inv});
            chk($sformatf("row%0d_itag", i), {24'd0, itag}, {24'd0, v[i].itag});
            chk($sformatf("row%0d_avld", i), {31'd0, avld}, {31'd0, v[i].av});
            chk($sformatf("row%0d_svld", i), {31'd0, svld}, {31'd0, v[i].sv});
            chk($sformatf("row%0d_perr", i), {31'd0, perr}, {31'd0, v[i].perr});
            if (v[i].av) begin
                chk($sformatf("row%0d_acmd", i), {28'd0, acmd}, {28'd0, v[i].ac});
                chk($sformatf("row%0d_atag", i), {28'd0, atag}, {28'd0, v[i].at});
                chk($sformatf("row%0d_ad1", i), ad1, D1[v[i].at[3:2]]);
                chk($sformatf("row%0d_ad2", i), ad2, D2[v[i].at[3:2]]);
            end
            if (v[i].sv) begin
                chk($sformatf("row%0d_scmd", i), {28'd0, scmd}, {28'd0, v[i].sc});
                chk($sformatf("row%0d_stag", i), {28'd0, stag}, {28'd0, v[i].st});
                chk($sformatf("row%0d_sd1", i), sd1, D1[v[i].st[3:2]]);
                chk($sformatf("row%0d_sd2", i), sd2, D2[v[i].st[3:2]]);
            end
        end

        // Reset clears the sticky error
        cmd_v = '0; tag_v = '0; adn = 1'b0; sdn = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("reset_clears_all", {31'd0, any_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // req1 add tag1 a=3 b=4 right after reset
        cmd_v = 16'h0001; tag_v = 8'h01;
        step();
        chk("t1_avld", {31'd0, avld}, 32'd1);
        chk("t1_acmd", {28'd0, acmd}, 32'd1);
        chk("t1_atag", {28'd0, atag}, 32'd1);
        chk("t1_ad1", ad1, 32'd3);
        chk("t1_ad2", ad2, 32'd4);
        chk("t1_ack", {28'd0, ack}, 32'd1);

        // Async reset mid-issue: outputs drop without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_zero", {31'd0, any_out()}, 32'd0);
        cmd_v = '0; tag_v = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // The op in flight before reset was dropped; its done is a protocol error
        adn = 1'b1; adt = 4'h1;
        step();
        adn = 1'b0;
        chk("post_rst_done_perr", {31'd0, perr}, 32'd1);
        chk("post_rst_no_vld", {31'd0, avld}, 32'd0);
        step();
        chk("perr_sticky", {31'd0, perr}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
